// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit:
// FSM states, opcode constants, ALU op codes and opcode classes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } stateE;

    typedef enum logic [2:0] {
        CL_R,
        CL_SLTI,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_ADDI,
        CL_BAD
    } opClassE;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_SLTI = 6'b000001;
    localparam logic [5:0] OP_LW   = 6'b000100;
    localparam logic [5:0] OP_SW   = 6'b000101;
    localparam logic [5:0] OP_BEQ  = 6'b000110;
    localparam logic [5:0] OP_ADDI = 6'b000111;

    localparam logic [2:0] ALU_R   = 3'b000;
    localparam logic [2:0] ALU_BEQ = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_ADD = 3'b011;

    function automatic logic [2:0] aluFor(input opClassE cls);
        logic [2:0] op;
        op = ALU_R;
        unique case (cls)
            CL_BEQ:                op = ALU_BEQ;
            CL_SLTI:               op = ALU_SLT;
            CL_LW, CL_SW, CL_ADDI: op = ALU_ADD;
            default:               op = ALU_R;
        endcase
        return op;
    endfunction

    function automatic logic usesImm(input opClassE cls);
        return (cls == CL_LW) || (cls == CL_SW) ||
               (cls == CL_ADDI) || (cls == CL_SLTI);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles for one access and flags the cycle
// in which the wait budget runs out.
module mem_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    // Fires during the LIMIT-th wait cycle; a ready in that cycle
    // drops enable, so a completing access never times out.
    assign timeout = enable && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: FETCH/DECODE/EXEC/MEM/WB FSM with
// stall freeze, illegal-opcode trap and memory timeout trap.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OPC_W       = 6,
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int TIMEOUT_EN  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPC_W-1:0]    opCode,
    input  logic                zero,
    input  logic                memReady,
    input  logic                stall,
    output logic                memReq,
    output logic                memRead,
    output logic                memWrite,
    output logic                iOrD,
    output logic                irWrite,
    output logic                pcWrite,
    output logic                pcSource,
    output logic                regDestination,
    output logic                aluSource,
    output logic                memToReg,
    output logic                regWrite,
    output logic                instrDone,
    output logic                illegalOp,
    output logic                busErr,
    output logic [ALU_OP_W-1:0] aluOpcode,
    output logic [2:0]          state
);

    localparam bit TO_ON = (TIMEOUT_EN != 0);

    stateE            curState;
    logic [OPC_W-1:0] opReg;
    opClassE          opClass;
    opClassE          newClass;
    logic             memPhase;
    logic             waitEn;
    logic             waitClr;
    logic             waitOut;
    logic             trapWait;
    logic             hold;

    function automatic opClassE classOf(input logic [OPC_W-1:0] op);
        opClassE c;
        c = CL_BAD;
        if (op == OPC_W'(OP_R))    c = CL_R;
        if (op == OPC_W'(OP_SLTI)) c = CL_SLTI;
        if (op == OPC_W'(OP_LW))   c = CL_LW;
        if (op == OPC_W'(OP_SW))   c = CL_SW;
        if (op == OPC_W'(OP_BEQ))  c = CL_BEQ;
        if (op == OPC_W'(OP_ADDI)) c = CL_ADDI;
        return c;
    endfunction

    assign opClass  = classOf(opReg);
    assign newClass = classOf(opCode);
    assign state    = curState;

    assign memPhase = (curState == FETCH) || (curState == MEM);
    assign waitEn   = memPhase && !stall && !memReady;
    assign waitClr  = !stall && ((memPhase && memReady) ||
                      curState == DECODE || curState == EXEC ||
                      curState == WB);
    assign trapWait = TO_ON && waitOut;

    mem_wait_timer #(
        .LIMIT(MEM_TIMEOUT)
    ) uTimer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (waitClr),
        .enable (waitEn),
        .timeout(waitOut)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            curState  <= FETCH;
            opReg     <= '0;
            illegalOp <= 1'b0;
            busErr    <= 1'b0;
        end else if (!(stall && curState != TRAP)) begin
            unique case (curState)
                FETCH: begin
                    if (memReady) begin
                        curState <= DECODE;
                    end else if (trapWait) begin
                        busErr   <= 1'b1;
                        curState <= TRAP;
                    end
                end
                DECODE: begin
                    opReg <= opCode;
                    if (newClass == CL_BAD) begin
                        illegalOp <= 1'b1;
                        curState  <= TRAP;
                    end else begin
                        curState <= EXEC;
                    end
                end
                EXEC: begin
                    unique case (opClass)
                        CL_BEQ:       curState <= FETCH;
                        CL_LW, CL_SW: curState <= MEM;
                        default:      curState <= WB;
                    endcase
                end
                MEM: begin
                    if (memReady) begin
                        curState <= (opClass == CL_LW) ? WB : FETCH;
                    end else if (trapWait) begin
                        busErr   <= 1'b1;
                        curState <= TRAP;
                    end
                end
                WB:      curState <= FETCH;
                TRAP:    curState <= TRAP;
                default: curState <= FETCH;
            endcase
        end
    end

    // Strobes are suppressed while frozen or held in reset so an
    // aborted access never issues a stray request or write.
    assign hold = stall || !rst_n;

    always_comb begin
        memReq         = 1'b0;
        memRead        = 1'b0;
        memWrite       = 1'b0;
        iOrD           = 1'b0;
        irWrite        = 1'b0;
        pcWrite        = 1'b0;
        pcSource       = 1'b0;
        regDestination = 1'b0;
        aluSource      = 1'b0;
        memToReg       = 1'b0;
        regWrite       = 1'b0;
        instrDone      = 1'b0;
        aluOpcode      = '0;
        unique case (curState)
            FETCH: begin
                memReq  = 1'b1;
                memRead = 1'b1;
                irWrite = memReady;
                pcWrite = memReady;
            end
            EXEC: begin
                aluOpcode = ALU_OP_W'(aluFor(opClass));
                aluSource = usesImm(opClass);
                if (opClass == CL_BEQ) begin
                    pcWrite   = zero;
                    pcSource  = 1'b1;
                    instrDone = 1'b1;
                end
            end
            MEM: begin
                memReq    = 1'b1;
                iOrD      = 1'b1;
                aluOpcode = ALU_OP_W'(ALU_ADD);
                aluSource = 1'b1;
                memRead   = (opClass == CL_LW);
                memWrite  = (opClass == CL_SW);
                instrDone = (opClass == CL_SW) && memReady;
            end
            WB: begin
                regWrite       = 1'b1;
                instrDone      = 1'b1;
                regDestination = (opClass == CL_R);
                memToReg       = (opClass == CL_LW);
                aluOpcode      = ALU_OP_W'(aluFor(opClass));
                aluSource      = usesImm(opClass);
            end
            default: begin
            end
        endcase
        if (hold) begin
            memReq    = 1'b0;
            memRead   = 1'b0;
            memWrite  = 1'b0;
            irWrite   = 1'b0;
            pcWrite   = 1'b0;
            regWrite  = 1'b0;
            instrDone = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-by-cycle vector bench for multicycle_control plus a
// hand-written addi latency sequence.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opCode;
    logic       zero;
    logic       memReady;
    logic       stall;
    logic       memReq, memRead, memWrite, iOrD, irWrite, pcWrite;
    logic       pcSource, regDestination, aluSource, memToReg;
    logic       regWrite, instrDone, illegalOp, busErr;
    logic [2:0] aluOpcode;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_control #(
        .OPC_W(6),
        .ALU_OP_W(3),
        .MEM_TIMEOUT(4),
        .TIMEOUT_EN(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .opCode(opCode),
        .zero(zero),
        .memReady(memReady),
        .stall(stall),
        .memReq(memReq),
        .memRead(memRead),
        .memWrite(memWrite),
        .iOrD(iOrD),
        .irWrite(irWrite),
        .pcWrite(pcWrite),
        .pcSource(pcSource),
        .regDestination(regDestination),
        .aluSource(aluSource),
        .memToReg(memToReg),
        .regWrite(regWrite),
        .instrDone(instrDone),
        .illegalOp(illegalOp),
        .busErr(busErr),
        .aluOpcode(aluOpcode),
        .state(state)
    );

    localparam logic [13:0] REQ  = 14'h2000;
    localparam logic [13:0] RD   = 14'h1000;
    localparam logic [13:0] WR   = 14'h0800;
    localparam logic [13:0] IORD = 14'h0400;
    localparam logic [13:0] IRW  = 14'h0200;
    localparam logic [13:0] PCW  = 14'h0100;
    localparam logic [13:0] PCS  = 14'h0080;
    localparam logic [13:0] RDST = 14'h0040;
    localparam logic [13:0] ASRC = 14'h0020;
    localparam logic [13:0] M2R  = 14'h0010;
    localparam logic [13:0] RGW  = 14'h0008;
    localparam logic [13:0] DONE = 14'h0004;
    localparam logic [13:0] ILL  = 14'h0002;
    localparam logic [13:0] BERR = 14'h0001;
    localparam logic [13:0] NONE = 14'h0000;
    localparam logic [13:0] FRDY = REQ | RD | IRW | PCW;
    localparam logic [13:0] FWT  = REQ | RD;

    typedef struct {
        logic       rstN;
        logic       stl;
        logic       rdy;
        logic       zr;
        logic [5:0] op;
        logic [2:0] st;
        logic [13:0] bits;
        logic [2:0] alu;
    } vecT;

    vecT vecs[$];

    function automatic vecT mk(input logic rstN, input logic stl,
                               input logic rdy, input logic zr,
                               input logic [5:0] op, input logic [2:0] st,
                               input logic [13:0] bits,
                               input logic [2:0] alu);
        vecT v;
        v.rstN = rstN;
        v.stl  = stl;
        v.rdy  = rdy;
        v.zr   = zr;
        v.op   = op;
        v.st   = st;
        v.bits = bits;
        v.alu  = alu;
        return v;
    endfunction

    function automatic logic [13:0] obs();
        return {memReq, memRead, memWrite, iOrD, irWrite, pcWrite,
                pcSource, regDestination, aluSource, memToReg,
                regWrite, instrDone, illegalOp, busErr};
    endfunction

    task automatic check(input string name, input int got,
                         input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got 'h%0h want 'h%0h", name, got, want);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        stall    = 1'b0;
        memReady = 1'b0;
        zero     = 1'b0;
        opCode   = 6'd0;

        // row 0: reset; 1-4: R-type
        vecs.push_back(mk(0, 0, 0, 0, 6'o00, 3'd0, NONE, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd0, FRDY, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd1, NONE, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd2, NONE, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd4, RGW | DONE | RDST, 3'b000));
        // lw with two MEM wait cycles
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd0, FRDY, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o04, 3'd1, NONE, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd2, ASRC, 3'b011));
        vecs.push_back(mk(1, 0, 0, 0, 6'o00, 3'd3, REQ | RD | IORD | ASRC, 3'b011));
        vecs.push_back(mk(1, 0, 0, 0, 6'o00, 3'd3, REQ | RD | IORD | ASRC, 3'b011));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd3, REQ | RD | IORD | ASRC, 3'b011));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd4, RGW | DONE | M2R | ASRC, 3'b011));
        // beq taken, then not taken
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd0, FRDY, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o06, 3'd1, NONE, 3'b000));
        vecs.push_back(mk(1, 0, 1, 1, 6'o00, 3'd2, PCW | PCS | DONE, 3'b001));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd0, FRDY, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o06, 3'd1, NONE, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd2, PCS | DONE, 3'b001));
        // slti
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd0, FRDY, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o01, 3'd1, NONE, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd2, ASRC, 3'b010));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd4, RGW | DONE | ASRC, 3'b010));
        // sw stalled 3 cycles in MEM, ready ignored while stalled
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd0, FRDY, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o05, 3'd1, NONE, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd2, ASRC, 3'b011));
        vecs.push_back(mk(1, 0, 0, 0, 6'o00, 3'd3, REQ | WR | IORD | ASRC, 3'b011));
        vecs.push_back(mk(1, 1, 1, 0, 6'o00, 3'd3, IORD | ASRC, 3'b011));
        vecs.push_back(mk(1, 1, 1, 0, 6'o00, 3'd3, IORD | ASRC, 3'b011));
        vecs.push_back(mk(1, 1, 0, 0, 6'o00, 3'd3, IORD | ASRC, 3'b011));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd3, REQ | WR | IORD | ASRC | DONE, 3'b011));
        // R-type reset mid-EXEC, no WB afterwards
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd0, FRDY, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd1, NONE, 3'b000));
        vecs.push_back(mk(0, 0, 1, 0, 6'o00, 3'd2, NONE, 3'b000));
        // FETCH timeout after 4 wait cycles
        vecs.push_back(mk(1, 0, 0, 0, 6'o00, 3'd0, FWT, 3'b000));
        vecs.push_back(mk(1, 0, 0, 0, 6'o00, 3'd0, FWT, 3'b000));
        vecs.push_back(mk(1, 0, 0, 0, 6'o00, 3'd0, FWT, 3'b000));
        vecs.push_back(mk(1, 0, 0, 0, 6'o00, 3'd0, FWT, 3'b000));
        vecs.push_back(mk(1, 0, 0, 0, 6'o00, 3'd5, BERR, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd5, BERR, 3'b000));
        vecs.push_back(mk(0, 0, 1, 0, 6'o00, 3'd5, BERR, 3'b000));
        // ready on the 4th cycle wins over timeout; then illegal op
        vecs.push_back(mk(1, 0, 0, 0, 6'o00, 3'd0, FWT, 3'b000));
        vecs.push_back(mk(1, 0, 0, 0, 6'o00, 3'd0, FWT, 3'b000));
        vecs.push_back(mk(1, 0, 0, 0, 6'o00, 3'd0, FWT, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd0, FRDY, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o77, 3'd1, NONE, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd5, ILL, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, 6'o00, 3'd5, ILL, 3'b000));
        vecs.push_back(mk(0, 0, 1, 0, 6'o00, 3'd5, ILL, 3'b000));
        vecs.push_back(mk(1, 0, 0, 0, 6'o00, 3'd0, FWT, 3'b000));

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst_n    = vecs[i].rstN;
            stall    = vecs[i].stl;
            memReady = vecs[i].rdy;
            zero     = vecs[i].zr;
            opCode   = vecs[i].op;
            @(negedge clk);
            check($sformatf("row%0d state", i), int'(state), int'(vecs[i].st));
            check($sformatf("row%0d ctrl", i), int'(obs()), int'(vecs[i].bits));
            check($sformatf("row%0d aluOp", i), int'(aluOpcode), int'(vecs[i].alu));
        end

        // addi: FETCH to instrDone inclusive is 4 cycles
        begin
            int  cyc;
            bit  seen;
            cyc  = 0;
            seen = 1'b0;
            @(posedge clk);
            #1;
            memReady = 1'b1;
            opCode   = 6'o07;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                cyc++;
                if (instrDone) begin
                    seen = 1'b1;
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
            check("addi done seen", int'(seen), 1);
            check("addi latency", cyc, 4);
            check("addi wb ctrl", int'(obs()), int'(RGW | DONE | ASRC));
            check("addi wb aluOp", int'(aluOpcode), 3);
            @(negedge clk);
            check("addi back to fetch", int'(state), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OPC_W, 6, opcode width.
REQ-002 Parameter ALU_OP_W, 3, ALU operation code width.
REQ-003 Parameter MEM_TIMEOUT, 16, maximum cycles spent waiting for memReady per access (range 1..255).
REQ-004 Parameter TIMEOUT_EN, 1, 1 enables the memory timeout trap; 0 waits indefinitely.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 Port clk, in, 1: rising-edge clock.
REQ-007 Port rst_n, in, 1: synchronous reset, active-low.
REQ-008 Port opCode, in, OPC_W: instruction opcode; SHALL be sampled only in DECODE.
REQ-009 Port zero, in, 1: ALU zero flag; used only in EXEC for beq.
REQ-010 Port memReady, in, 1: memory completion for the current memReq cycle.
REQ-011 Port stall, in, 1: freeze request.
REQ-012 Outputs, 1 bit each: memReq, memRead, memWrite, iOrD (0 = PC address, 1 = ALU address), irWrite, pcWrite, pcSource (0 = PC+4, 1 = branch target), regDestination, aluSource, memToReg, regWrite, instrDone (1-cycle pulse), illegalOp (sticky), busErr (sticky).
REQ-013 Port aluOpcode, out, ALU_OP_W.
REQ-014 Port state, out, 3: current state encoding, for debug.

Function
REQ-015 States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-016 All outputs SHALL be decoded combinationally from the state register and the latched opcode opReg; every output not named for a state SHALL be 0.
REQ-017 FETCH: memReq=1, memRead=1, iOrD=0.
  - On memReady: irWrite=1, pcWrite=1, pcSource=0, next state DECODE.
REQ-018 DECODE: opReg<=opCode.
  - Legal opcodes go to EXEC.
  - Any other opcode sets illegalOp and goes to TRAP.
REQ-019 Legal opcodes: R-type 000000, slti 000001, lw 000100, sw 000101, beq 000110, addi 000111.
REQ-020 EXEC aluOpcode: R=000, beq=001, slti=010, lw/sw/addi=011.
  - aluSource=1 for lw, sw, addi, slti; 0 otherwise.
REQ-021 EXEC next state: R/addi/slti go to WB; lw/sw go to MEM.
  - beq: pcWrite=zero, pcSource=1, instrDone=1, next state FETCH.
REQ-022 MEM: memReq=1, iOrD=1, aluOpcode=011, aluSource=1; memRead=1 for lw, memWrite=1 for sw.
  - On memReady, sw pulses instrDone and goes to FETCH; lw goes to WB.
REQ-023 WB lasts exactly one cycle and then goes to FETCH.
  - Outputs: regWrite=1, instrDone=1.
  - regDestination=1 for R-type; memToReg=1 for lw.
  - aluOpcode and aluSource hold their EXEC values for opReg.
REQ-024 Wait counter (8 bit):
  - Cleared on entry to FETCH or MEM and on memReady.
  - Increments on each FETCH/MEM cycle with memReady=0.
  - With TIMEOUT_EN=1, reaching MEM_TIMEOUT sets busErr and goes to TRAP on the next edge.
  - memReady in the same cycle as the timeout takes priority: the access completes.
REQ-025 stall=1 in any non-TRAP state:
  - State, opReg and counter hold.
  - memReq, memRead, memWrite, irWrite, pcWrite, regWrite and instrDone are forced 0.
  - memReady is ignored.
REQ-026 TRAP: all control outputs are 0; illegalOp and busErr hold; the block leaves TRAP only via reset.
REQ-027 Latency with zero memory waits and no stall, FETCH to instrDone inclusive: beq 3, R/addi/slti/sw 4, lw 5 cycles. Each memory wait cycle adds 1.

Reset
REQ-028 When rst_n=0 at a clk edge, the following SHALL be cleared:
  - state to FETCH;
  - opReg to 000000;
  - counter, illegalOp and busErr to 0.
REQ-029 Reset in any state, including mid-MEM, SHALL abort the instruction with no further strobes; FETCH begins on the first edge with rst_n=1.

Structure
REQ-030 Opcode constants, ALU op codes and the state encoding SHALL live in shared package ctrl_pkg.
REQ-031 The wait counter and timeout compare SHALL be sub-module mem_wait_timer (ports: clk, rst_n, clear, enable, timeout).

Verification
REQ-032 Scenario: R-type (000000), memReady always 1 -> FETCH, DECODE, EXEC, WB; regWrite=1 and regDestination=1 only in cycle 4; instrDone at cycle 4.
REQ-033 Scenario: lw (000100), memReady delayed 2 cycles in MEM -> MEM held 3 cycles with memRead=1 and iOrD=1; WB with memToReg=1; instrDone at cycle 7.
REQ-034 Scenario: beq (000110) with zero=1, then again with zero=0 -> pcWrite=1, pcSource=1 in EXEC the first time; pcWrite=0 the second time; both finish in 3 cycles.
REQ-035 Scenario: opcode 111111 -> TRAP one cycle after DECODE; illegalOp=1 until rst_n=0.
REQ-036 Scenario: MEM_TIMEOUT=4, memReady held 0 in FETCH -> busErr=1 and state=5 after 4 wait cycles. Repeat with memReady=1 at cycle 4 -> no trap.
REQ-037 Scenario: stall=1 for 3 cycles mid-MEM of sw, then rst_n=0 mid-EXEC -> memWrite is 0 while stalled and resumes afterwards; after reset, state=0 and no regWrite pulse.
